// File: rtl/sal_bk_ctrl_pp_pkg.sv
// Shared types for the per-bank DDR2 controller: page policy and bank state.
package sal_bk_ctrl_pp_pkg;

    // Page policy selected at run time; encoding 3 falls back to PP_OPEN.
    typedef enum logic [1:0] {
        PP_OPEN    = 2'd0,
        PP_CLOSE   = 2'd1,
        PP_TIMEOUT = 2'd2
    } page_policy_e;

    // Bank state; the encoding is kept fixed so older status decoders still match.
    typedef enum logic [0:0] {
        ST_CLOSED = 1'b0,
        ST_OPEN   = 1'b1
    } bank_state_e;

endpackage

// File: rtl/sal_bk_ctrl_pp_dly_cntr.sv
// Down-counter for one DRAM timing constraint. Loading value N holds met_o low
// for N-1 cycles after the load, so the dependent command is legal N cycles
// after the grant; N=0 behaves like N=1.
module sal_dly_cntr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         met_o
);

    logic [W-1:0] cnt;

    // Load max(val-1, 0) on the grant, otherwise count down to zero and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= (val_i == '0) ? '0 : val_i - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign met_o = (cnt == '0);

endmodule

// File: rtl/sal_bk_ctrl_pp.sv
// Per-bank DDR2 controller: tracks the open row, enforces per-bank timing and
// requests ACT/RD/WR/PRE/REF under OPEN, CLOSE or TIMEOUT page policy. A
// pending refresh pre-empts row hits and closes the bank on its own.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_CLOSED | no row open; may request REF (priority) or ACT
//   ST_OPEN   | row open_ra open; may request RD/WR on hit, PRE on miss,
//             | refresh or policy-driven close
module sal_bk_ctrl_pp
    import sal_bk_ctrl_pp_pkg::*;
#(
    parameter int RA_WIDTH   = 14,
    parameter int CA_WIDTH   = 10,
    parameter int TW         = 8,
    parameter int IDLE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            page_policy_i,
    input  logic [IDLE_WIDTH-1:0] idle_timeout_i,
    input  logic [TW-1:0]         t_rcd_i,
    input  logic [TW-1:0]         t_rp_i,
    input  logic [TW-1:0]         t_ras_i,
    input  logic [TW-1:0]         t_rfc_i,
    input  logic [TW-1:0]         t_rtp_i,
    input  logic [TW-1:0]         t_wtp_i,
    input  logic                  req_valid_i,
    input  logic                  req_wr_i,
    input  logic [RA_WIDTH-1:0]   req_ra_i,
    input  logic [CA_WIDTH-1:0]   req_ca_i,
    output logic                  req_ready_o,
    output logic                  act_req_o,
    output logic                  rd_req_o,
    output logic                  wr_req_o,
    output logic                  pre_req_o,
    output logic                  ref_req_o,
    input  logic                  act_gnt_i,
    input  logic                  rd_gnt_i,
    input  logic                  wr_gnt_i,
    input  logic                  pre_gnt_i,
    input  logic                  ref_gnt_i,
    output logic [RA_WIDTH-1:0]   sched_ra_o,
    output logic [CA_WIDTH-1:0]   sched_ca_o,
    input  logic                  aref_req_i,
    output logic                  aref_gnt_o,
    output logic                  bank_open_o,
    output logic [RA_WIDTH-1:0]   open_ra_o
);

    bank_state_e           state;
    logic [RA_WIDTH-1:0]   open_ra;
    logic [IDLE_WIDTH-1:0] idle_cnt;

    logic rcd_met, ras_met, rp_met, rfc_met, rtp_met, wtp_met;
    logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire;
    logic hit, pre_ok, idle_expired;

    // A grant only counts when it answers our own request.
    assign act_fire = act_req_o & act_gnt_i;
    assign rd_fire  = rd_req_o  & rd_gnt_i;
    assign wr_fire  = wr_req_o  & wr_gnt_i;
    assign pre_fire = pre_req_o & pre_gnt_i;
    assign ref_fire = ref_req_o & ref_gnt_i;

    sal_dly_cntr #(.W(TW)) u_rcd (.clk(clk), .rst(rst), .load_i(act_fire), .val_i(t_rcd_i), .met_o(rcd_met));
    sal_dly_cntr #(.W(TW)) u_ras (.clk(clk), .rst(rst), .load_i(act_fire), .val_i(t_ras_i), .met_o(ras_met));
    sal_dly_cntr #(.W(TW)) u_rp  (.clk(clk), .rst(rst), .load_i(pre_fire), .val_i(t_rp_i),  .met_o(rp_met));
    sal_dly_cntr #(.W(TW)) u_rfc (.clk(clk), .rst(rst), .load_i(ref_fire), .val_i(t_rfc_i), .met_o(rfc_met));
    sal_dly_cntr #(.W(TW)) u_rtp (.clk(clk), .rst(rst), .load_i(rd_fire),  .val_i(t_rtp_i), .met_o(rtp_met));
    sal_dly_cntr #(.W(TW)) u_wtp (.clk(clk), .rst(rst), .load_i(wr_fire),  .val_i(t_wtp_i), .met_o(wtp_met));

    assign hit          = req_valid_i && (req_ra_i == open_ra);
    assign pre_ok       = ras_met && rtp_met && wtp_met;
    assign idle_expired = (idle_cnt >= idle_timeout_i);

    // Command requests; refresh outranks row hits, and everything is muted in reset.
    always_comb begin
        act_req_o = 1'b0;
        rd_req_o  = 1'b0;
        wr_req_o  = 1'b0;
        pre_req_o = 1'b0;
        ref_req_o = 1'b0;
        if (!rst) begin
            if (state == ST_CLOSED) begin
                if (rp_met && rfc_met) begin
                    if (aref_req_i) begin
                        ref_req_o = 1'b1;
                    end else if (req_valid_i) begin
                        act_req_o = 1'b1;
                    end
                end
            end else begin
                if (aref_req_i) begin
                    pre_req_o = pre_ok;
                end else if (hit) begin
                    rd_req_o = rcd_met && !req_wr_i;
                    wr_req_o = rcd_met && req_wr_i;
                end else if (req_valid_i) begin
                    pre_req_o = pre_ok;
                end else begin
                    case (page_policy_i)
                        PP_CLOSE:   pre_req_o = pre_ok;
                        PP_TIMEOUT: pre_req_o = pre_ok && idle_expired;
                        default:    pre_req_o = 1'b0;
                    endcase
                end
            end
        end
    end

    // Bank state and open row; reset drops the row without a precharge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLOSED;
            open_ra <= '0;
        end else if (act_fire) begin
            state   <= ST_OPEN;
            open_ra <= req_ra_i;
        end else if (pre_fire) begin
            state   <= ST_CLOSED;
        end
    end

    // Idle counter: counts request-free cycles while open, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (act_fire || req_valid_i) begin
            idle_cnt <= '0;
        end else if (state == ST_OPEN && idle_cnt != '1) begin
            idle_cnt <= idle_cnt + IDLE_WIDTH'(1);
        end
    end

    assign req_ready_o = rd_fire | wr_fire;
    assign aref_gnt_o  = ref_fire;
    assign sched_ra_o  = req_ra_i;
    assign sched_ca_o  = req_ca_i;
    assign bank_open_o = (state == ST_OPEN);
    assign open_ra_o   = open_ra;

endmodule

// File: tb/tb_sal_bk_ctrl_pp.sv
// Scoreboard bench for sal_bk_ctrl_pp: the stimulus pushes the hand-computed
// command (kind, cycle, row) it expects, and a monitor pops on every granted
// command. The bench acts as a scheduler that grants every request at once.
module tb_sal_bk_ctrl_pp;

    localparam int C_ACT = 0;
    localparam int C_RD  = 1;
    localparam int C_WR  = 2;
    localparam int C_PRE = 3;
    localparam int C_REF = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  page_policy;
    logic [7:0]  idle_timeout;
    logic [7:0]  t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp;
    logic        req_valid, req_wr;
    logic [13:0] req_ra;
    logic [9:0]  req_ca;
    logic        req_ready;
    logic        act_req, rd_req, wr_req, pre_req, ref_req;
    logic        act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [13:0] sched_ra;
    logic [9:0]  sched_ca;
    logic        aref_req, aref_gnt;
    logic        bank_open;
    logic [13:0] open_ra;

    int cyc;
    int n_cmp;
    int n_err;

    typedef struct {
        int cmd;
        int cyc;
        int ra;
    } exp_t;
    exp_t exp_q[$];

    sal_bk_ctrl_pp dut (
        .clk(clk), .rst(rst),
        .page_policy_i(page_policy), .idle_timeout_i(idle_timeout),
        .t_rcd_i(t_rcd), .t_rp_i(t_rp), .t_ras_i(t_ras),
        .t_rfc_i(t_rfc), .t_rtp_i(t_rtp), .t_wtp_i(t_wtp),
        .req_valid_i(req_valid), .req_wr_i(req_wr), .req_ra_i(req_ra), .req_ca_i(req_ca),
        .req_ready_o(req_ready),
        .act_req_o(act_req), .rd_req_o(rd_req), .wr_req_o(wr_req),
        .pre_req_o(pre_req), .ref_req_o(ref_req),
        .act_gnt_i(act_gnt), .rd_gnt_i(rd_gnt), .wr_gnt_i(wr_gnt),
        .pre_gnt_i(pre_gnt), .ref_gnt_i(ref_gnt),
        .sched_ra_o(sched_ra), .sched_ca_o(sched_ca),
        .aref_req_i(aref_req), .aref_gnt_o(aref_gnt),
        .bank_open_o(bank_open), .open_ra_o(open_ra)
    );

    // Scheduler model: grants exactly what is requested, so no stray grants.
    assign act_gnt = act_req;
    assign rd_gnt  = rd_req;
    assign wr_gnt  = wr_req;
    assign pre_gnt = pre_req;
    assign ref_gnt = ref_req;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act_v, input int exp_v);
        n_cmp++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act_v, exp_v);
        end
    endtask

    task automatic push(input int c, input int t, input int r);
        exp_t e;
        e.cmd = c;
        e.cyc = t;
        e.ra  = r;
        exp_q.push_back(e);
    endtask

    // Advance to just after the posedge that starts cycle n.
    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every granted command must match the head of the scoreboard.
    always @(negedge clk) begin
        int   cmd;
        exp_t e;
        cmd = -1;
        if (act_req && act_gnt)      cmd = C_ACT;
        else if (rd_req && rd_gnt)   cmd = C_RD;
        else if (wr_req && wr_gnt)   cmd = C_WR;
        else if (pre_req && pre_gnt) cmd = C_PRE;
        else if (ref_req && ref_gnt) cmd = C_REF;
        if (cmd >= 0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_cmd: got cmd %0d at cycle %0d, expected none", cmd, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("cmd_kind", cmd, e.cmd);
                chk("cmd_cycle", cyc, e.cyc);
                if (cmd == C_ACT || cmd == C_RD || cmd == C_WR)
                    chk("cmd_row", int'(sched_ra), e.ra);
                chk("ready_pulse", int'(req_ready), int'(cmd == C_RD || cmd == C_WR));
                chk("aref_gnt_pulse", int'(aref_gnt), int'(cmd == C_REF));
            end
        end
    end

    initial begin
        cyc          = 0;
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        page_policy  = 2'd0;
        idle_timeout = 8'd0;
        t_rcd = 8'd3; t_rp = 8'd2; t_ras = 8'd6;
        t_rfc = 8'd5; t_rtp = 8'd2; t_wtp = 8'd4;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_ra    = 14'd5;
        req_ca    = 10'h012;
        aref_req  = 1'b0;

        // Outputs muted while reset is high even with requests present.
        go(1); aref_req = 1'b1; #1;
        chk("rst_act_forced", int'(act_req), 0);
        chk("rst_ref_forced", int'(ref_req), 0);
        chk("rst_aref_gnt", int'(aref_gnt), 0);
        chk("rst_ready", int'(req_ready), 0);
        go(2); aref_req = 1'b0;

        // OPEN policy: ACT row 5 at 3, RD after tRCD=3 at 6.
        go(3); rst = 1'b0;
        push(C_ACT, 3, 5); push(C_RD, 6, 5);
        #1;
        chk("reset_bank_open", int'(bank_open), 0);
        chk("reset_open_ra", int'(open_ra), 0);
        chk("sched_ca_pass", int'(sched_ca), 'h012);
        go(7); req_valid = 1'b0;

        // Miss to row 9: PRE waits for tRAS (3+6=9), ACT after tRP=2, RD after tRCD.
        go(8); req_valid = 1'b1; req_ra = 14'd9;
        push(C_PRE, 9, 0); push(C_ACT, 11, 9); push(C_RD, 14, 9);
        #1;
        chk("open_after_hit", int'(bank_open), 1);
        chk("open_ra_row5", int'(open_ra), 5);
        chk("pre_held_ras", int'(pre_req), 0);

        // CLOSE policy: write hit at 15, PRE after tWTP=4 at 19.
        go(15); page_policy = 2'd1; req_wr = 1'b1;
        push(C_WR, 15, 9);
        go(16); req_valid = 1'b0;
        push(C_PRE, 19, 0);
        go(18); #1;
        chk("pre_held_wtp", int'(pre_req), 0);
        go(20); page_policy = 2'd2; idle_timeout = 8'd10; #1;
        chk("closed_after_pre", int'(bank_open), 0);

        // TIMEOUT policy: hit at 24, re-hit at 31 clears idle, PRE once idle reaches 10.
        go(21); req_valid = 1'b1; req_wr = 1'b0; req_ra = 14'd4;
        push(C_ACT, 21, 4); push(C_RD, 24, 4);
        go(25); req_valid = 1'b0;
        go(31); req_valid = 1'b1;
        push(C_RD, 31, 4);
        go(32); req_valid = 1'b0;
        push(C_PRE, 42, 0);
        go(35); #1;
        chk("idle_cleared_by_hit", int'(pre_req), 0);

        // Refresh pre-emption on an open row-3 bank with a hit pending.
        go(43); page_policy = 2'd0;
        go(44); req_valid = 1'b1; req_ra = 14'd3;
        push(C_ACT, 44, 3);
        go(46); aref_req = 1'b1;
        push(C_PRE, 50, 0); push(C_REF, 52, 0); push(C_ACT, 57, 3); push(C_RD, 60, 3);
        go(47); #1;
        chk("ref_beats_hit", int'(rd_req), 0);
        go(53); #1;
        chk("aref_gnt_one_cycle", int'(aref_gnt), 0);
        chk("ref_held_rfc", int'(ref_req), 0);
        go(54); aref_req = 1'b0;
        go(56); #1;
        chk("act_held_rfc", int'(act_req), 0);

        // Reset while open with counters loaded: abandons the row, ACT immediately.
        go(61); req_valid = 1'b0; rst = 1'b1;
        go(62); rst = 1'b0; req_valid = 1'b1; req_ra = 14'd7;
        push(C_ACT, 62, 7); push(C_RD, 65, 7);
        #1;
        chk("rst_mid_closed", int'(bank_open), 0);
        chk("rst_mid_open_ra", int'(open_ra), 0);
        chk("rst_mid_act_now", int'(act_req), 1);
        go(66); req_valid = 1'b0; page_policy = 2'd1;
        push(C_PRE, 68, 0);

        go(75);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
